// File: rtl/joystick_event_gen.sv
// Multi-axis joystick event generator: classifies a time-multiplexed ADC sample
// stream with hysteresis, debounces per axis and emits event pulses with auto-repeat.

module joystick_axis #(
   parameter int DATA_W        = 12,
   parameter int ENTER_LOW     = 1000,
   parameter int EXIT_LOW      = 1800,
   parameter int EXIT_HIGH     = 2300,
   parameter int ENTER_HIGH    = 3000,
   parameter int DEBOUNCE_N    = 4,
   parameter int REPEAT_DELAY  = 500000,
   parameter int REPEAT_PERIOD = 100000,
   parameter int CNT_W         = 20
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   input  logic              hit_i,
   input  logic [DATA_W-1:0] data_i,
   input  logic              repeat_en_i,
   output logic              evt_high_o,
   output logic              evt_low_o,
   output logic              level_high_o,
   output logic              level_low_o
);
   localparam int DBW = $clog2(DEBOUNCE_N + 1);
   localparam logic [DBW-1:0]    DBN          = DBW'(DEBOUNCE_N);
   localparam logic [DATA_W-1:0] ENTER_LOW_C  = DATA_W'(ENTER_LOW);
   localparam logic [DATA_W-1:0] EXIT_LOW_C   = DATA_W'(EXIT_LOW);
   localparam logic [DATA_W-1:0] EXIT_HIGH_C  = DATA_W'(EXIT_HIGH);
   localparam logic [DATA_W-1:0] ENTER_HIGH_C = DATA_W'(ENTER_HIGH);
   localparam logic [CNT_W-1:0]  RPT_DLY      = CNT_W'(REPEAT_DELAY - 1);
   localparam logic [CNT_W-1:0]  RPT_PER      = CNT_W'(REPEAT_PERIOD - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_PEND_HIGH, S_PEND_LOW, S_HELD_HIGH, S_HELD_LOW
   } state_e;

   state_e           st_q, st_d;
   logic [DBW-1:0]   cnt_q, cnt_d;
   logic [CNT_W-1:0] rpt_q, rpt_d;
   logic             evt_hi_q, evt_hi_d, evt_lo_q, evt_lo_d;
   logic             q_hi, q_lo;
   logic             beg_hi, beg_lo, ent_hi, ent_lo;

   assign q_hi = (data_i >= ENTER_HIGH_C);
   assign q_lo = (data_i <= ENTER_LOW_C);

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         st_q     <= S_IDLE;
         cnt_q    <= '0;
         rpt_q    <= '0;
         evt_hi_q <= 1'b0;
         evt_lo_q <= 1'b0;
      end else begin
         st_q     <= st_d;
         cnt_q    <= cnt_d;
         rpt_q    <= rpt_d;
         evt_hi_q <= evt_hi_d;
         evt_lo_q <= evt_lo_d;
      end
   end

   always_comb begin
      st_d     = st_q;
      cnt_d    = cnt_q;
      rpt_d    = rpt_q;
      evt_hi_d = 1'b0;
      evt_lo_d = 1'b0;
      beg_hi   = 1'b0;
      beg_lo   = 1'b0;
      ent_hi   = 1'b0;
      ent_lo   = 1'b0;

      // Repeat timer runs every cycle while held; a release below overrides it.
      if (st_q == S_HELD_HIGH || st_q == S_HELD_LOW) begin
         if (!repeat_en_i) begin
            rpt_d = RPT_DLY;
         end else if (rpt_q == '0) begin
            rpt_d    = RPT_PER;
            evt_hi_d = (st_q == S_HELD_HIGH);
            evt_lo_d = (st_q == S_HELD_LOW);
         end else begin
            rpt_d = rpt_q - 1'b1;
         end
      end

      if (hit_i) begin
         unique case (st_q)
            S_IDLE: begin
               beg_hi = q_hi;
               beg_lo = q_lo;
            end
            S_PEND_HIGH: begin
               if (q_hi) begin
                  cnt_d  = cnt_q + 1'b1;
                  ent_hi = (cnt_d == DBN);
               end else if (q_lo) begin
                  beg_lo = 1'b1;
               end else begin
                  st_d  = S_IDLE;
                  cnt_d = '0;
               end
            end
            S_PEND_LOW: begin
               if (q_lo) begin
                  cnt_d  = cnt_q + 1'b1;
                  ent_lo = (cnt_d == DBN);
               end else if (q_hi) begin
                  beg_hi = 1'b1;
               end else begin
                  st_d  = S_IDLE;
                  cnt_d = '0;
               end
            end
            S_HELD_HIGH: begin
               if (data_i < EXIT_HIGH_C) begin
                  st_d     = S_IDLE;
                  cnt_d    = '0;
                  rpt_d    = '0;
                  evt_hi_d = 1'b0;
                  evt_lo_d = 1'b0;
                  beg_lo   = q_lo;
               end
            end
            S_HELD_LOW: begin
               if (data_i > EXIT_LOW_C) begin
                  st_d     = S_IDLE;
                  cnt_d    = '0;
                  rpt_d    = '0;
                  evt_hi_d = 1'b0;
                  evt_lo_d = 1'b0;
                  beg_hi   = q_hi;
               end
            end
            default: ;
         endcase
      end

      // A fresh qualifying sample either starts a debounce run or, with no debounce, enters directly.
      if (beg_hi) begin
         if (DEBOUNCE_N == 1) begin
            ent_hi = 1'b1;
         end else begin
            st_d  = S_PEND_HIGH;
            cnt_d = DBW'(1);
         end
      end
      if (beg_lo) begin
         if (DEBOUNCE_N == 1) begin
            ent_lo = 1'b1;
         end else begin
            st_d  = S_PEND_LOW;
            cnt_d = DBW'(1);
         end
      end
      if (ent_hi) begin
         st_d     = S_HELD_HIGH;
         cnt_d    = '0;
         rpt_d    = RPT_DLY;
         evt_hi_d = 1'b1;
         evt_lo_d = 1'b0;
      end
      if (ent_lo) begin
         st_d     = S_HELD_LOW;
         cnt_d    = '0;
         rpt_d    = RPT_DLY;
         evt_hi_d = 1'b0;
         evt_lo_d = 1'b1;
      end
   end

   always_comb begin
      evt_high_o   = evt_hi_q;
      evt_low_o    = evt_lo_q;
      level_high_o = (st_q == S_HELD_HIGH);
      level_low_o  = (st_q == S_HELD_LOW);
   end
endmodule

module joystick_event_gen #(
   parameter int NUM_AXES      = 2,
   parameter int AXIS_W        = 1,
   parameter int DATA_W        = 12,
   parameter int ENTER_LOW     = 1000,
   parameter int EXIT_LOW      = 1800,
   parameter int EXIT_HIGH     = 2300,
   parameter int ENTER_HIGH    = 3000,
   parameter int DEBOUNCE_N    = 4,
   parameter int REPEAT_DELAY  = 500000,
   parameter int REPEAT_PERIOD = 100000,
   parameter int CNT_W         = 20
) (
   input  logic                clk_1MHz,
   input  logic                rst_n,
   input  logic                sample_valid,
   input  logic [AXIS_W-1:0]   sample_axis,
   input  logic [DATA_W-1:0]   sample_data,
   input  logic                repeat_en,
   output logic [NUM_AXES-1:0] evt_high,
   output logic [NUM_AXES-1:0] evt_low,
   output logic [NUM_AXES-1:0] level_high,
   output logic [NUM_AXES-1:0] level_low,
   output logic                bad_axis
);
   if (!(ENTER_LOW < EXIT_LOW && EXIT_LOW <= EXIT_HIGH && EXIT_HIGH < ENTER_HIGH)) begin : g_bad_thr
      $error("joystick_event_gen: need ENTER_LOW < EXIT_LOW <= EXIT_HIGH < ENTER_HIGH");
   end
   if (NUM_AXES < 1 || NUM_AXES > (1 << AXIS_W) || DEBOUNCE_N < 1 ||
       REPEAT_DELAY < 2 || REPEAT_PERIOD < 2 || REPEAT_DELAY >= (1 << CNT_W) ||
       REPEAT_PERIOD >= (1 << CNT_W) || ENTER_HIGH >= (1 << DATA_W)) begin : g_bad_size
      $error("joystick_event_gen: inconsistent NUM_AXES/AXIS_W/DEBOUNCE_N/REPEAT/CNT_W/DATA_W");
   end

   logic [NUM_AXES-1:0] hit;
   logic                oob;
   logic                bad_axis_q;

   always_comb begin
      for (int a = 0; a < NUM_AXES; a++) begin
         hit[a] = sample_valid && (sample_axis == AXIS_W'(a));
      end
   end

   assign oob = sample_valid && (32'(sample_axis) >= 32'(NUM_AXES));

   // Sticky until reset so a misconfigured sequencer is visible to software.
   always_ff @(posedge clk_1MHz or negedge rst_n) begin
      if (!rst_n)   bad_axis_q <= 1'b0;
      else if (oob) bad_axis_q <= 1'b1;
   end
   assign bad_axis = bad_axis_q;

   for (genvar g = 0; g < NUM_AXES; g++) begin : g_axis
      joystick_axis #(
         .DATA_W(DATA_W), .ENTER_LOW(ENTER_LOW), .EXIT_LOW(EXIT_LOW),
         .EXIT_HIGH(EXIT_HIGH), .ENTER_HIGH(ENTER_HIGH), .DEBOUNCE_N(DEBOUNCE_N),
         .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD), .CNT_W(CNT_W)
      ) u_axis (
         .clk_i       (clk_1MHz),
         .rst_n_i     (rst_n),
         .hit_i       (hit[g]),
         .data_i      (sample_data),
         .repeat_en_i (repeat_en),
         .evt_high_o  (evt_high[g]),
         .evt_low_o   (evt_low[g]),
         .level_high_o(level_high[g]),
         .level_low_o (level_low[g])
      );
   end
endmodule

// File: doc/joystick_event_gen.md
Name: joystick_event_gen

Overview:
- Parametrised successor to the two-axis joystick direction detector.
- Consumes a time-multiplexed stream of ADC samples, one tagged sample per valid cycle, for NUM_AXES axes.
- Per axis, classifies each sample against hysteresis thresholds, debounces over consecutive samples, and emits one-cycle direction event pulses with optional hold-to-auto-repeat.
- Sits between the XADC DRP sequencer and menu/game control logic.

Parameters:
- NUM_AXES, 2, number of independent axes (>=1).
- AXIS_W, 1, width of the axis index; 2**AXIS_W >= NUM_AXES.
- DATA_W, 12, sample width, unsigned.
- ENTER_LOW, 1000, a sample <= this qualifies LOW.
- EXIT_LOW, 1800, a held LOW releases when a sample > this.
- EXIT_HIGH, 2300, a held HIGH releases when a sample < this.
- ENTER_HIGH, 3000, a sample >= this qualifies HIGH.
- DEBOUNCE_N, 4, consecutive qualifying samples of the same axis required to assert (>=1).
- REPEAT_DELAY, 500000, clock cycles from the initial event to the first repeat (>=2).
- REPEAT_PERIOD, 100000, clock cycles between subsequent repeats (>=2).
- CNT_W, 20, repeat counter width; must hold max(REPEAT_DELAY, REPEAT_PERIOD).

Ports:
- clk_1MHz  input  1  sole clock; everything is on the rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- sample_valid  input  1  sample_axis/sample_data valid this cycle.
- sample_axis  input  AXIS_W  axis index of the sample.
- sample_data  input  DATA_W  unsigned ADC code.
- repeat_en  input  1  enables auto-repeat on all axes.
- evt_high  output  NUM_AXES  one-cycle pulse per axis: HIGH event (right/up).
- evt_low  output  NUM_AXES  one-cycle pulse per axis: LOW event (left/down).
- level_high  output  NUM_AXES  axis currently in HELD_HIGH.
- level_low  output  NUM_AXES  axis currently in HELD_LOW.
- bad_axis  output  1  sticky flag: a valid sample arrived with sample_axis >= NUM_AXES.

Behaviour:
- Reset, asynchronous: all outputs 0, every axis IDLE, debounce and repeat counters 0. Reset mid-hold or mid-debounce discards state and emits no pulse.
- Elaboration check, simulation $error: ENTER_LOW < EXIT_LOW <= EXIT_HIGH < ENTER_HIGH, DEBOUNCE_N >= 1, and the width constraints above.
- Per-axis FSM states: IDLE, PEND_HIGH, PEND_LOW, HELD_HIGH, HELD_LOW. The FSM advances only on cycles where sample_valid=1 and sample_axis addresses that axis. Other axes hold their state.
- A sample is qualifying HIGH if data >= ENTER_HIGH and qualifying LOW if data <= ENTER_LOW. Comparisons are unsigned and inclusive as written.
- IDLE: qualifying HIGH -> PEND_HIGH with cnt=1. Qualifying LOW -> PEND_LOW with cnt=1. Otherwise stay.
- PEND_x: a same-direction qualifying sample increments cnt. When cnt reaches DEBOUNCE_N -> HELD_x and fire the event.
- PEND_x: an opposite-direction qualifying sample -> PEND_opposite with cnt=1. A non-qualifying sample -> IDLE with cnt=0.
- DEBOUNCE_N=1: IDLE goes directly to HELD_x and fires on the first qualifying sample.
- HELD_HIGH: a sample < EXIT_HIGH releases to IDLE with no event. If that sample is also qualifying LOW, go to PEND_LOW with cnt=1 instead (or HELD_LOW plus event if DEBOUNCE_N=1). HELD_LOW mirrors this using EXIT_LOW.
- Samples inside the hysteresis band never change a HELD state.
- Event latency: the evt bit is registered. It is high exactly in the cycle after the valid cycle of the sample that completes debounce, for one cycle.
- level_high/level_low are registered state bits that update on the same edge as the event.
- Auto-repeat, per axis:
  - On entry to HELD_x, rpt_cnt loads REPEAT_DELAY-1.
  - Each cycle in HELD_x with repeat_en=1, rpt_cnt decrements. At 0, the evt_x bit pulses in the next cycle and rpt_cnt reloads REPEAT_PERIOD-1.
  - With repeat_en=0, rpt_cnt is held at REPEAT_DELAY-1 and no repeats fire. When repeat_en rises again, the full delay restarts.
- Collisions:
  - If a release sample and rpt_cnt=0 coincide, release wins and no pulse fires.
  - Entry and repeat pulses cannot coincide, because entry reloads the counter.
  - Different axes may pulse in the same cycle only through repeats.
- Out-of-range sample_axis: the sample is ignored by all axes and bad_axis is set; it clears only on reset.

Test Plan:
- Reset, then 4 valid samples on axis 0 at 3500 (DEBOUNCE_N=4) -> evt_high[0] pulses once, exactly 1 cycle after the 4th valid; level_high[0]=1; no further pulse while holding at 3500 with repeat_en=0.
- Axis 0 samples 3500, 3500, 2050, 3500, 3500, 3500, 3500 -> no pulse until the 7th sample (the debounce count restarts after 2050), then one pulse.
- Held HIGH on axis 1, then samples 2500 and 2800 -> stays held with no events. Sample 2200 -> level_high[1]=0 with no event. Then 4 x 500 -> evt_low[1] pulses.
- repeat_en=1 with small params (REPEAT_DELAY=20, REPEAT_PERIOD=5), holding axis 0 HIGH -> repeat pulses at 20, 25, 30... cycles after the initial pulse. Drop repeat_en at cycle 27 -> no pulse at 30.
- Interleaved axes: axis0=3500 and axis1=500 alternating, 4 each -> evt_high[0] and evt_low[1] each pulse once, in different cycles. sample_axis=2 with NUM_AXES=2 -> bad_axis=1 and no state change.
- Assert rst_n low mid-PEND and mid-HELD -> all outputs drop to 0 immediately; after release, 3 more qualifying samples produce no event.
